stage_enable_sequencer: RTL

//  Issue/stage-enable controller for the 5-stage MIPS datapath. Each cycle it decides whether the

---
 rtl/stage_enable_sequencer_pkg.sv | 43 ++++
 rtl/stage_enable_sequencer_token_shift.sv | 24 ++
 rtl/stage_enable_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/stage_enable_sequencer_pkg.sv
// Shared ISA definitions for the issue sequencer: opcode fields, FSM states
// and a small decode helper that sorts an opcode into an instruction class.
package mips_isa_defs;

    localparam int OP_MSB = 19;
    localparam int OP_LSB = 15;

    localparam logic [4:0] OP_HLT        = 5'b10001;
    localparam logic [4:0] OP_LD         = 5'b10100;
    localparam logic [2:0] OP_JMP_PREFIX = 3'b111;

    localparam int BUB_W = 8;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALT   = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        INS_NORMAL = 2'd0,
        INS_LD     = 2'd1,
        INS_JMP    = 2'd2,
        INS_HLT    = 2'd3
    } ins_class_e;

    // Halt outranks jump outranks load; a class whose bubble count is zero
    // decays to normal so it never enters BUBBLE.
    function automatic ins_class_e classify_op(input logic [4:0] op,
                                               input logic     ldHasBubbles,
                                               input logic     jmpHasBubbles);
        if (op == OP_HLT)
            return INS_HLT;
        else if ((op[4:2] == OP_JMP_PREFIX) && jmpHasBubbles)
            return INS_JMP;
        else if ((op == OP_LD) && ldHasBubbles)
            return INS_LD;
        else
            return INS_NORMAL;
    endfunction

endpackage

// File: rtl/stage_enable_sequencer_token_shift.sv
// Valid-token shift register: one bit per pipeline stage, fed by the issue
// strobe, so each stage enable fires a fixed number of cycles after issue.
module stage_token_shift #(
    parameter int DEPTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_token,
    output logic [DEPTH-1:0] o_en
);

    logic [DEPTH-1:0] r_en;

    // The cast keeps the low DEPTH bits, which also covers DEPTH == 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_en <= '0;
        else
            r_en <= DEPTH'({r_en, i_token});
    end

    assign o_en = r_en;

endmodule

// File: rtl/stage_enable_sequencer.sv
// Issue/stage-enable controller for the 5-stage MIPS datapath: decides issue,
// inserts load/jump bubbles, drains on halt and counts issued instructions.
module stage_enable_sequencer
    import mips_isa_defs::*;
#(
    parameter int DEPTH       = 5,
    parameter int LD_BUBBLES  = 1,
    parameter int JMP_BUBBLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [19:0]      Ins,
    input  logic             Ins_valid,
    input  logic             Resume,
    output logic             Issue,
    output logic [DEPTH-1:0] En,
    output logic             Halted,
    output logic [CNT_W-1:0] Inst_cnt
);

    localparam logic [BUB_W-1:0] LD_RELOAD  = BUB_W'((LD_BUBBLES  > 0) ? LD_BUBBLES  - 1 : 0);
    localparam logic [BUB_W-1:0] JMP_RELOAD = BUB_W'((JMP_BUBBLES > 0) ? JMP_BUBBLES - 1 : 0);

    seq_state_e       r_state;
    logic [BUB_W-1:0] r_bub_cnt;
    logic             r_halted;
    logic [CNT_W-1:0] r_inst_cnt;

    logic             w_issue;
    ins_class_e       w_class;
    logic [DEPTH-1:0] w_en_next;
    logic             w_drain_done;
    logic             w_unused_ins_bits;

    assign w_unused_ins_bits = ^Ins[OP_LSB-1:0];

    // Reset gates issue directly, since the state already reads RUN while held in reset.
    assign w_issue = Rst_n && (r_state == ST_RUN) && Ins_valid;
    assign w_class = classify_op(Ins[OP_MSB:OP_LSB], LD_BUBBLES != 0, JMP_BUBBLES != 0);

    // Leave DRAIN one edge early so Halted lands in the first cycle En is empty.
    assign w_en_next    = En << 1;
    assign w_drain_done = (w_en_next == '0);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= ST_RUN;
            r_bub_cnt <= '0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_issue) begin
                        case (w_class)
                            INS_HLT: r_state <= ST_DRAIN;
                            INS_JMP: begin
                                r_state   <= ST_BUBBLE;
                                r_bub_cnt <= JMP_RELOAD;
                            end
                            INS_LD: begin
                                r_state   <= ST_BUBBLE;
                                r_bub_cnt <= LD_RELOAD;
                            end
                            default: r_state <= ST_RUN;
                        endcase
                    end
                end
                ST_BUBBLE: begin
                    if (r_bub_cnt == '0)
                        r_state <= ST_RUN;
                    else
                        r_bub_cnt <= r_bub_cnt - 1'b1;
                end
                ST_DRAIN: begin
                    if (w_drain_done) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (Resume) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            r_inst_cnt <= '0;
        else if (w_issue && (r_inst_cnt != '1))
            r_inst_cnt <= r_inst_cnt + 1'b1;
    end

    stage_token_shift #(
        .DEPTH(DEPTH)
    ) u_token_shift (
        .i_clk   (Clk),
        .i_rst_n (Rst_n),
        .i_token (w_issue),
        .o_en    (En)
    );

    assign Issue    = w_issue;
    assign Halted   = r_halted;
    assign Inst_cnt = r_inst_cnt;

endmodule
